ram_responder: RTL
==================

// Module: ram_responder
// PURPOSE
//  RAM-side responder for the memory-controller <-> RAM bus (Ren, Wen, ramaddr, ramstore -> ramload, busy_o).
//  Word-addressed storage model with a programmable wait-state count; it latches one request and holds busy_o while waiting.
//  It then commits the write or returns the read word. Sits below the memory controller in the top-level SoC and the test benches.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; must be a power of two
//  LATENCY      2     wait cycles between request acceptance and completion; legal range 1..15
// PORTS
//  clk        in   1   system clock, rising edge
//  nRst       in   1   asynchronous active-low reset
//  Ren        in   1   read request from memory controller
//  Wen        in   1   write request from memory controller
//  ramaddr    in   32  byte address (word_t); bits [1:0] ignored
//  ramstore   in   32  write data (word_t)
//  ramload    out  32  read data (word_t), registered
//  busy_o     out  1   responder busy; controller completes the access when it samples 0
//  addr_err_o out  1   only with RAM_BOUNDS_CHECK_EN; out-of-range access flag
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, ramload=32'h0, busy_o=0, addr_err_o=0. Storage contents are not reset.
//  - Reset mid-operation aborts the access. A write is not committed unless its commit edge preceded nRst falling.
//  - FSM ram_state_t {IDLE, WAIT, DONE}:
//    IDLE: if (Ren|Wen) at edge T, latch op/addr/data, cnt<=LATENCY-1, go WAIT; else stay.
//    WAIT: cnt decrements each cycle. At cnt==0, the edge performs the access and goes to DONE.
//    DONE: one cycle; ramload is valid; go IDLE unconditionally.
//  - busy_o = (IDLE & (Ren|Wen)) | WAIT. This is combinational from Ren/Wen in IDLE, so the controller sees busy in the request cycle.
//  - Timing: request first seen in cycle T -> busy_o high T..T+LATENCY -> busy_o low with valid data in T+LATENCY+1.
//  - Write: mem[idx]<=latched data on the edge entering DONE; ramload keeps its previous value.
//  - Read: ramload<=mem[idx] on the same edge; ramload then holds until the next read completes.
//  - idx = latched ramaddr[$clog2(DEPTH_WORDS)+1:2]. Ren/Wen/ramaddr/ramstore changes during WAIT are ignored.
//  - Ren&Wen together: treated as a write; ramload unchanged.
//  - A request still asserted when DONE returns to IDLE is accepted as a new access. The controller must drop Ren/Wen after sampling busy_o=0.
//  - Back-to-back: a request held continuously yields one access every LATENCY+2 cycles.
// CONFIGURATION
//  RAM_BOUNDS_CHECK_EN defined:
//    - Adds addr_err_o. A latched ramaddr >= 4*DEPTH_WORDS is out of range.
//    - Out-of-range writes are suppressed; out-of-range reads return RAM_BAD_DATA (32'hBAD0_BAD0).
//    - addr_err_o=1 for the DONE cycle only.
//  RAM_BOUNDS_CHECK_EN undefined:
//    - No addr_err_o port. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
// STRUCTURE
//  - cpu_pkg: word_t (existing); add ram_state_t enum and RAM_BAD_DATA constant.
//  - One sub-module ram_word_array (DEPTH_WORDS x 32, 1 synchronous write and 1 synchronous read port, no reset).
//  - FSM, counter and request latch stay in ram_responder.
// TESTING
//  1. Reset: hold nRst=0 with Ren=1 -> busy_o=0, ramload=0; release nRst -> busy_o=1 in the same cycle the request is seen.
//  2. Write then read, LATENCY=2: Wen, addr 0x10, data 0xCAFEF00D.
//     -> busy_o high 3 cycles, low in cycle 4. A later Ren to 0x10 -> ramload=0xCAFEF00D in its 4th cycle.
//  3. Latching: change ramaddr to 0x20 and ramstore to 0x1 during WAIT of a write to 0x14.
//     -> mem word 5 = original data; word 8 untouched.
//  4. Ren&Wen=1 at addr 0x8, data 0x55 -> word 2 = 0x55; ramload keeps its prior value.
//  5. Reset mid-WAIT of a write to 0x4 -> word 1 unchanged; state IDLE, busy_o=0 after release.
//  6. Out-of-range addr 4*DEPTH_WORDS+4 (DEPTH_WORDS=1024, ramaddr=0x1004):
//     with RAM_BOUNDS_CHECK_EN -> read returns 0xBAD0BAD0 and addr_err_o pulses 1 cycle;
//     without -> access aliases word 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side types: the bus word, the RAM responder state encoding and
// the pattern returned for out-of-range reads.
package cpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } ram_state_t;

    localparam word_t RAM_BAD_DATA = 32'hBAD0_BAD0;

endpackage

// File: rtl/ram_word_array.sv
// Word storage behind the RAM responder: one synchronous write port and one
// synchronous read port, contents are deliberately not reset.
module ram_word_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// RAM-side responder with programmable wait states. Define RAM_BOUNDS_CHECK_EN
// to add the addr_err_o port and reject accesses beyond the array.
module ram_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        Ren,
    input  logic        Wen,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
`ifdef RAM_BOUNDS_CHECK_EN
    output logic        addr_err_o,
`endif
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    ram_state_t    state;
    ram_state_t    next_state;
    logic [3:0]    cnt;
    logic          op_write;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_data;
    logic          lat_oob;
    logic          rd_valid;
    logic          rd_bad;
    logic [31:0]   rd_data;
    logic          req;
    logic          access_edge;
    logic          unused_addr_bits;

    assign req              = Ren | Wen;
    assign access_edge      = (state == WAIT) && (cnt == 4'd0);
    assign unused_addr_bits = ^{ramaddr[31:AW+2], ramaddr[1:0]};

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = WAIT;
            WAIT:    if (cnt == 4'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch: everything the access needs is frozen on acceptance.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt      <= 4'd0;
            op_write <= 1'b0;
            lat_idx  <= '0;
            lat_data <= 32'h0;
        end else if (state == IDLE && req) begin
            cnt      <= 4'(LATENCY - 1);
            op_write <= Wen;
            lat_idx  <= ramaddr[AW+1:2];
            lat_data <= ramstore;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

`ifdef RAM_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            lat_oob <= 1'b0;
        end else if (state == IDLE && req) begin
            lat_oob <= |ramaddr[31:AW+2];
        end
    end
`else
    assign lat_oob = 1'b0;
`endif

    // The array read register is not reset, so a flag decides whether ramload
    // shows it, the bad-data pattern, or zero after reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rd_valid <= 1'b0;
            rd_bad   <= 1'b0;
        end else if (access_edge && !op_write) begin
            rd_valid <= 1'b1;
            rd_bad   <= lat_oob;
        end
    end

    ram_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .wr_en  (access_edge && op_write && !lat_oob),
        .wr_idx (lat_idx),
        .wr_data(lat_data),
        .rd_en  (access_edge && !op_write && !lat_oob),
        .rd_idx (lat_idx),
        .rd_data(rd_data)
    );

    always_comb begin
        busy_o = nRst && ((state == IDLE && req) || state == WAIT);
`ifdef RAM_BOUNDS_CHECK_EN
        addr_err_o = (state == DONE) && lat_oob;
`endif
        if (!rd_valid) begin
            ramload = 32'h0;
        end else if (rd_bad) begin
            ramload = RAM_BAD_DATA;
        end else begin
            ramload = rd_data;
        end
    end

endmodule
